// File: rtl/alu_resp_checker_if.sv
// rtl/alu_resp_checker_if.sv - operand/result bus and statistics outputs of the ALU response checker
interface alu_resp_checker_if #(
  parameter int N  = 16,
  parameter int CW = 8
);
  logic          start;
  logic          stop;
  logic          in_valid;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [2:0]    op;
  logic [N-1:0]  result;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic          err;
  logic [CW-1:0] first_fail_idx;
  logic [N-1:0]  first_fail_exp;
  logic [N-1:0]  first_fail_got;

  modport master (
    output start, stop, in_valid, a, b, op, result,
    input  busy, done, pass_cnt, fail_cnt, err,
           first_fail_idx, first_fail_exp, first_fail_got
  );

  modport slave (
    input  start, stop, in_valid, a, b, op, result,
    output busy, done, pass_cnt, fail_cnt, err,
           first_fail_idx, first_fail_exp, first_fail_got
  );
endinterface

// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - latency-matched reference model and pass/fail scoreboard for the registered ALU
module alu_resp_checker #(
  parameter int N    = 16,
  parameter int LAT  = 1,
  parameter int NCHK = 16,
  parameter int CW   = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHK - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_pass;
  logic [CW-1:0] r_fail;
  logic          r_err;
  logic [CW-1:0] r_ff_idx;
  logic [N-1:0]  r_ff_exp;
  logic [N-1:0]  r_ff_got;
  logic [LAT-1:0] r_pv;
  logic [N-1:0]  r_pexp [LAT];
  logic [CW-1:0] r_pidx [LAT];

  logic          w_start;
  logic          w_launch;
  logic          w_last;
  logic          w_cmp;
  logic          w_match;
  logic [N-1:0]  w_exp;
  logic [N-1:0]  w_cexp;

  function automatic logic [N-1:0] f_ref(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                         input logic [2:0] fop);
    case (fop)
      3'd0:    f_ref = fa + fb;
      3'd1:    f_ref = fa - fb;
      3'd2:    f_ref = fa & fb;
      3'd3:    f_ref = fa | fb;
      3'd4:    f_ref = fa ^ fb;
      3'd5:    f_ref = fa << 1;
      3'd6:    f_ref = fa >> 1;
      default: f_ref = ~fa;
    endcase
  endfunction

  // start only counts when the pipeline is guaranteed empty
  assign w_start  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_launch = (r_state == S_RUN) && bus.in_valid;
  assign w_last   = w_launch && (r_idx == LAST_IDX);
  assign w_exp    = f_ref(bus.a, bus.b, bus.op);
  assign w_cmp    = r_pv[LAT-1];
  assign w_cexp   = r_pexp[LAT-1];
  assign w_match  = (w_cexp == bus.result);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (bus.stop || w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_pv == '0) w_next = S_DONE;
      S_DONE:  if (bus.start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_idx <= '0;
    else if (w_start)  r_idx <= '0;
    else if (w_launch) r_idx <= r_idx + CW'(1);
  end

  // Stage LAT-1 lines up with the result the ALU presents on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pexp[i] <= '0;
        r_pidx[i] <= '0;
      end
    end else begin
      r_pv[0]   <= w_launch;
      r_pexp[0] <= w_exp;
      r_pidx[0] <= r_idx;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pexp[i] <= r_pexp[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass   <= '0;
      r_fail   <= '0;
      r_err    <= 1'b0;
      r_ff_idx <= '0;
      r_ff_exp <= '0;
      r_ff_got <= '0;
    end else if (w_start) begin
      r_pass   <= '0;
      r_fail   <= '0;
      r_err    <= 1'b0;
      r_ff_idx <= '0;
      r_ff_exp <= '0;
      r_ff_got <= '0;
    end else if (w_cmp) begin
      if (w_match) begin
        if (r_pass != CNT_MAX) r_pass <= r_pass + CW'(1);
      end else begin
        if (r_fail != CNT_MAX) r_fail <= r_fail + CW'(1);
        if (!r_err) begin
          r_err    <= 1'b1;
          r_ff_idx <= r_pidx[LAT-1];
          r_ff_exp <= w_cexp;
          r_ff_got <= bus.result;
        end
      end
    end
  end

  assign bus.busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done           = (r_state == S_DONE);
  assign bus.pass_cnt       = r_pass;
  assign bus.fail_cnt       = r_fail;
  assign bus.err            = r_err;
  assign bus.first_fail_idx = r_ff_idx;
  assign bus.first_fail_exp = r_ff_exp;
  assign bus.first_fail_got = r_ff_got;

endmodule

// File: tb/tb_alu_resp_checker.sv
// tb/tb_alu_resp_checker.sv - scoreboard bench driving LAT=1 and LAT=3 checkers with identical directed vectors
module tb_alu_resp_checker;

  typedef struct {
    logic [15:0] exp;
    logic [15:0] got;
    logic [7:0]  idx;
    int          cyc;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        s_launch;
  logic [15:0] s_exp;
  logic [15:0] s_got;
  logic [7:0]  s_idx;
  int          n_launch;
  int          n_vec;
  int          n_fail;
  int          qsz [2];

  logic        busy_w [2];
  logic        done_w [2];
  logic [7:0]  pass_w [2];
  logic [7:0]  fail_w [2];
  logic        err_w  [2];
  logic [7:0]  ffi_w  [2];
  logic [15:0] ffe_w  [2];
  logic [15:0] ffg_w  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT_G = (g == 0) ? 1 : 3;

    alu_resp_checker_if #(.N(16), .CW(8)) bus ();

    logic [15:0] rline [LAT_G];
    ent_t        q [$];
    ent_t        pe;
    ent_t        me;
    ent_t        ff;
    bit          ff_seen;
    int          lcyc;
    logic [7:0]  ppc;
    logic [7:0]  pfc;
    logic [7:0]  pc;
    logic [7:0]  fc;

    assign bus.start    = start;
    assign bus.stop     = stop;
    assign bus.in_valid = in_valid;
    assign bus.a        = a;
    assign bus.b        = b;
    assign bus.op       = op;
    assign bus.result   = rline[LAT_G-1];

    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign pass_w[g] = bus.pass_cnt;
    assign fail_w[g] = bus.fail_cnt;
    assign err_w[g]  = bus.err;
    assign ffi_w[g]  = bus.first_fail_idx;
    assign ffe_w[g]  = bus.first_fail_exp;
    assign ffg_w[g]  = bus.first_fail_got;

    alu_resp_checker #(.N(16), .LAT(LAT_G), .NCHK(16), .CW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // ALU stand-in: returns the scripted value LAT edges after the operands
    always @(posedge clk) begin
      rline[0] <= s_got;
      for (int i = 1; i < LAT_G; i++) rline[i] <= rline[i-1];
    end

    initial begin
      lcyc    = 0;
      ff_seen = 1'b0;
      ppc     = '0;
      pfc     = '0;
    end

    always @(posedge clk) begin
      lcyc++;
      if (s_launch && rst_n) begin
        pe.exp = s_exp;
        pe.got = s_got;
        pe.idx = s_idx;
        pe.cyc = lcyc;
        q.push_back(pe);
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        ppc     = '0;
        pfc     = '0;
        ff_seen = 1'b0;
      end else begin
        pc = bus.pass_cnt;
        fc = bus.fail_cnt;
        if (pc != ppc || fc != pfc) begin
          if (pc == 8'd0 && fc == 8'd0) begin
            ff_seen = 1'b0;
          end else if (q.size() == 0) begin
            chk($sformatf("L%0d_stray_cmp", g), 32'(pc) + 32'(fc), 32'(ppc) + 32'(pfc));
          end else begin
            me = q.pop_front();
            if (me.exp == me.got) begin
              chk($sformatf("L%0d_pass_inc idx%0d", g, me.idx), pc, ppc + 8'd1);
              chk($sformatf("L%0d_fail_hold idx%0d", g, me.idx), fc, pfc);
            end else begin
              chk($sformatf("L%0d_fail_inc idx%0d", g, me.idx), fc, pfc + 8'd1);
              chk($sformatf("L%0d_pass_hold idx%0d", g, me.idx), pc, ppc);
              if (!ff_seen) begin
                ff      = me;
                ff_seen = 1'b1;
              end
            end
            chk($sformatf("L%0d_latency idx%0d", g, me.idx), lcyc - me.cyc, LAT_G);
            if (ff_seen) begin
              chk($sformatf("L%0d_err", g), bus.err, 1);
              chk($sformatf("L%0d_ff_idx", g), bus.first_fail_idx, ff.idx);
              chk($sformatf("L%0d_ff_exp", g), bus.first_fail_exp, ff.exp);
              chk($sformatf("L%0d_ff_got", g), bus.first_fail_got, ff.got);
            end
          end
          ppc = pc;
          pfc = fc;
        end
      end
      qsz[g] = q.size();
    end
  end

  task automatic chk_state(input string nm, input bit bz, input bit dn,
                           input int pc, input int fc, input bit er);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_L%0d_busy", nm, l), busy_w[l], bz);
      chk($sformatf("%s_L%0d_done", nm, l), done_w[l], dn);
      chk($sformatf("%s_L%0d_pass", nm, l), pass_w[l], pc);
      chk($sformatf("%s_L%0d_fail", nm, l), fail_w[l], fc);
      chk($sformatf("%s_L%0d_err", nm, l), err_w[l], er);
    end
  endtask

  task automatic chk_ff(input string nm, input int idx, input int e, input int g);
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("%s_L%0d_ffidx", nm, l), ffi_w[l], idx);
      chk($sformatf("%s_L%0d_ffexp", nm, l), ffe_w[l], e);
      chk($sformatf("%s_L%0d_ffgot", nm, l), ffg_w[l], g);
    end
  endtask

  task automatic quiet();
    in_valid = 1'b0;
    stop     = 1'b0;
    start    = 1'b0;
    s_launch = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      quiet();
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic [2:0] top,
                      input logic [15:0] texp, input logic [15:0] tgot,
                      input bit tlaunch, input bit tstop);
    @(negedge clk);
    start    = 1'b0;
    a        = ta;
    b        = tb_;
    op       = top;
    in_valid = 1'b1;
    stop     = tstop;
    s_exp    = texp;
    s_got    = tgot;
    s_launch = tlaunch;
    s_idx    = 8'(n_launch);
    if (tlaunch) n_launch++;
  endtask

  task automatic do_start(input string nm);
    @(negedge clk);
    quiet();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n_launch = 0;
    chk_state({nm, "_start"}, 1, 0, 0, 0, 0);
    chk_ff({nm, "_start"}, 0, 0, 0);
  endtask

  // Counts edges from the last launch edge until done is seen in each lane
  task automatic wait_done(input string nm);
    int k0;
    int k1;
    k0 = -1;
    k1 = -1;
    @(negedge clk);
    quiet();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done_w[0] && k0 < 0) k0 = k;
      if (done_w[1] && k1 < 0) k1 = k;
    end
    chk({nm, "_L0_done_edge"}, k0, 2);
    chk({nm, "_L1_done_edge"}, k1, 4);
  endtask

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    n_launch = 0;
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    s_exp    = '0;
    s_got    = '0;
    s_idx    = '0;
    quiet();
    repeat (3) @(negedge clk);
    chk_state("reset", 0, 0, 0, 0, 0);
    chk_ff("reset", 0, 0, 0);
    rst_n = 1'b1;

    send(16'h1234, 16'h0001, 3'd0, 16'h1235, 16'h0000, 0, 0);
    idle(3);
    chk_state("idle_ignore", 0, 0, 0, 0, 0);

    do_start("t1");
    send(16'd10,    16'd20,    3'd0, 16'd30,    16'd30,    1, 0);
    send(16'd50,    16'd3,     3'd1, 16'd47,    16'd47,    1, 0);
    send(16'h0F0F,  16'h00FF,  3'd2, 16'h000F,  16'h000F,  1, 0);
    send(16'h0F0F,  16'h00FF,  3'd3, 16'h0FFF,  16'h0FFF,  1, 1);
    wait_done("t1");
    chk_state("t1_end", 0, 1, 4, 0, 0);

    do_start("t2");
    send(16'h0001,  16'h0001,  3'd0, 16'h0002,  16'h0002,  1, 0);
    send(16'hF0F0,  16'h0FF0,  3'd4, 16'hFF00,  16'hFF00,  1, 0);
    send(16'h0F0F,  16'h00FF,  3'd2, 16'h000F,  16'h0000,  1, 0);
    send(16'h1234,  16'h0000,  3'd7, 16'hEDCB,  16'hEDCB,  1, 0);
    send(16'h8001,  16'h0000,  3'd6, 16'h4000,  16'h1111,  1, 1);
    wait_done("t2");
    chk_state("t2_end", 0, 1, 3, 2, 1);
    chk_ff("t2_end", 2, 16'h000F, 16'h0000);

    do_start("t3");
    send(16'hFFFF,  16'h0001,  3'd0, 16'h0000,  16'h0000,  1, 0);
    send(16'h0000,  16'h0001,  3'd1, 16'hFFFF,  16'hFFFF,  1, 0);
    send(16'h8001,  16'h0000,  3'd5, 16'h0002,  16'h0002,  1, 0);
    send(16'h00F0,  16'h0F00,  3'd3, 16'h0FF0,  16'h0FF0,  1, 1);
    wait_done("t3");
    chk_state("t3_end", 0, 1, 4, 0, 0);

    do_start("t4");
    for (int i = 0; i < 20; i++)
      send(16'(i), 16'd3, 3'd0, 16'(i + 3), 16'(i + 3), i < 16, 0);
    idle(6);
    chk_state("t4_end", 0, 1, 16, 0, 0);

    do_start("t5");
    send(16'h0001,  16'h0001,  3'd0, 16'h0002,  16'h0009,  1, 0);
    send(16'h0005,  16'h0006,  3'd0, 16'h000B,  16'h000B,  1, 1);
    @(negedge clk);
    quiet();
    chk("t5_L0_fail_before_rst", fail_w[0], 1);
    chk("t5_L0_err_before_rst", err_w[0], 1);
    chk("t5_L0_busy_drain", busy_w[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk_state("t5_rst", 0, 0, 0, 0, 0);
    chk_ff("t5_rst", 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk_state("t5_post_rst", 0, 0, 0, 0, 0);

    do_start("t6");
    send(16'h0003,  16'h0004,  3'd0, 16'h0007,  16'h0007,  1, 0);
    send(16'h0009,  16'h0002,  3'd1, 16'h0007,  16'h0007,  1, 0);
    send(16'hFF00,  16'h0F0F,  3'd4, 16'hF00F,  16'hF00F,  1, 1);
    wait_done("t6");
    chk_state("t6_end", 0, 1, 3, 0, 0);

    idle(3);
    chk("L0_queue_empty", qsz[0], 0);
    chk("L1_queue_empty", qsz[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
